mem_io_responder: RTL and testbench

//  Responder end of the processor's synchronous memory bus (ADDR/DOUT/W out, DIN in).

---
 rtl/mem_io_responder_if.sv | 9 +
 rtl/mem_io_responder.sv | 61 ++++++
 tb/tb_mem_io_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: processor memory bus (ADDR/DOUT/W out of processor, DIN back)
interface mem_io_responder_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  modport master (output ADDR, output DOUT, output W, input DIN);
  modport slave (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-bus responder (RAM, LEDR, synchronised SW, optional MEM_IO_TIMER_EN countdown timer)
module mem_io_responder #(
  parameter int RAM_AW = 8,
  parameter int LED_W  = 10,
  parameter int SW_W   = 10
) (
  input  logic                Clock,
  input  logic                Resetn,
  mem_io_responder_if.slave   bus,
  input  logic [SW_W-1:0]     SW,
  output logic [LED_W-1:0]    LEDR
);
  logic [15:0]       ram [2**RAM_AW];
  logic [3:0]        region;
  logic [RAM_AW-1:0] ram_a;
  logic [SW_W-1:0]   sw1, sw2;
  logic [15:0]       tmr_rd, rd;
  assign region = bus.ADDR[15:12];
  assign ram_a  = bus.ADDR[RAM_AW-1:0];
  // RAM write; the read mux samples the word before this edge, so same-word reads see old data
  always_ff @(posedge Clock)
    if (Resetn && bus.W && region == 4'h0) ram[ram_a] <= bus.DOUT;
  // LED register load
  always_ff @(posedge Clock)
    if (!Resetn) LEDR <= '0;
    else if (bus.W && region == 4'h1) LEDR <= bus.DOUT[LED_W-1:0];
  // two-flop switch synchroniser
  always_ff @(posedge Clock)
    if (!Resetn) {sw2, sw1} <= '0;
    else {sw2, sw1} <= {sw1, SW};
`ifdef MEM_IO_TIMER_EN
  logic [15:0] cnt;
  logic        running, done, ld, clr, set;
  assign ld  = bus.W && region == 4'h5 && !bus.ADDR[0];
  assign clr = bus.W && region == 4'h5 && bus.ADDR[0];
  assign set = ld ? bus.DOUT == 16'h0 : running && cnt == 16'h1;
  assign tmr_rd = bus.ADDR[0] ? {15'b0, done} : cnt;
  // countdown: a load restarts the count, reaching zero raises done; a coincident set beats clear
  always_ff @(posedge Clock)
    if (!Resetn) begin
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      cnt     <= ld ? bus.DOUT : running ? cnt - 16'h1 : cnt;
      running <= ld ? bus.DOUT != 16'h0 : running && cnt != 16'h1;
      done    <= set || (done && !clr);
    end
`else
  assign tmr_rd = 16'h0;
`endif
  // read data select for the address presented this cycle
  always_comb
    rd = region == 4'h0 ? ram[ram_a] :
         region == 4'h1 ? 16'(LEDR) :
         region == 4'h3 ? 16'(sw2) :
         region == 4'h5 ? tmr_rd : 16'h0;
  // registered read data, one cycle of latency
  always_ff @(posedge Clock)
    bus.DIN <= Resetn ? rd : 16'h0;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder (timer checks under MEM_IO_TIMER_EN)
module tb_mem_io_responder;
  logic       Clock = 1'b0;
  logic       Resetn;
  logic [9:0] SW;
  logic [9:0] LEDR;
  int total = 0;
  int bad   = 0;
  mem_io_responder_if bus ();
  mem_io_responder #(.RAM_AW(8), .LED_W(10), .SW_W(10)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus.slave),
    .SW    (SW),
    .LEDR  (LEDR)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
    bus.ADDR = a;
    bus.DOUT = d;
    bus.W    = w;
    @(posedge Clock);
    #1;
  endtask
  initial begin
    Resetn = 1'b0;
    SW = 10'h3FF;
    cyc(16'h1000, 16'hFFFF, 1'b1);
    check("rst_din0", bus.DIN, 16'h0000);
    check("rst_led0", 16'(LEDR), 16'h0000);
    cyc(16'h0012, 16'hFFFF, 1'b1);
    check("rst_din1", bus.DIN, 16'h0000);
    check("rst_led1", 16'(LEDR), 16'h0000);
    Resetn = 1'b1;
    SW = 10'h000;
    for (int i = 0; i < 3; i++) cyc(16'h2000, 16'h0, 1'b0);
    cyc(16'h0012, 16'hBEEF, 1'b1);
    cyc(16'h0012, 16'h0, 1'b0);
    check("ram_rd", bus.DIN, 16'hBEEF);
    cyc(16'h0112, 16'h0, 1'b0);
    check("ram_alias", bus.DIN, 16'hBEEF);
    cyc(16'h0012, 16'h1234, 1'b1);
    check("ram_rdw_old", bus.DIN, 16'hBEEF);
    cyc(16'h0012, 16'h0, 1'b0);
    check("ram_new", bus.DIN, 16'h1234);
    cyc(16'h1000, 16'hFFFF, 1'b1);
    check("led_wr", 16'(LEDR), 16'h03FF);
    cyc(16'h1000, 16'h0, 1'b0);
    check("led_rd", bus.DIN, 16'h03FF);
    cyc(16'h3000, 16'hFFFF, 1'b1);
    check("sw_wr_din", bus.DIN, 16'h0000);
    check("sw_wr_led", 16'(LEDR), 16'h03FF);
    cyc(16'h0012, 16'h0, 1'b0);
    check("sw_wr_ram", bus.DIN, 16'h1234);
    cyc(16'h3000, 16'h0, 1'b0);
    SW = 10'h155;
    cyc(16'h3000, 16'h0, 1'b0);
    check("sw_e1", bus.DIN, 16'h0000);
    cyc(16'h3000, 16'h0, 1'b0);
    check("sw_e2", bus.DIN, 16'h0000);
    cyc(16'h3000, 16'h0, 1'b0);
    check("sw_e3", bus.DIN, 16'h0155);
    cyc(16'h7000, 16'hFFFF, 1'b1);
    check("unm_7000", bus.DIN, 16'h0000);
    cyc(16'h1000, 16'h0, 1'b0);
    check("unm_led", bus.DIN, 16'h03FF);
    cyc(16'hF00F, 16'h0, 1'b0);
    check("unm_F00F", bus.DIN, 16'h0000);
`ifdef MEM_IO_TIMER_EN
    cyc(16'h5000, 16'h0005, 1'b1);
    cyc(16'h5000, 16'h0, 1'b0);
    check("tmr_cnt", bus.DIN, 16'h0005);
    for (int j = 2; j <= 6; j++) begin
      cyc(16'h5001, 16'h0, 1'b0);
      check($sformatf("tmr_poll%0d", j), bus.DIN, (j == 6) ? 16'h1 : 16'h0);
    end
    cyc(16'h5001, 16'h0, 1'b1);
    check("tmr_clr_old", bus.DIN, 16'h0001);
    cyc(16'h5001, 16'h0, 1'b0);
    check("tmr_clr", bus.DIN, 16'h0000);
    cyc(16'h5000, 16'h0002, 1'b1);
    cyc(16'h5001, 16'h0, 1'b0);
    check("tmr_mid", bus.DIN, 16'h0000);
    cyc(16'h5001, 16'h0, 1'b1);
    check("tmr_race_old", bus.DIN, 16'h0000);
    cyc(16'h5001, 16'h0, 1'b0);
    check("tmr_set_wins", bus.DIN, 16'h0001);
    cyc(16'h5001, 16'h0, 1'b1);
    cyc(16'h5001, 16'h0, 1'b0);
    check("tmr_clr2", bus.DIN, 16'h0000);
    cyc(16'h5000, 16'h0000, 1'b1);
    cyc(16'h5001, 16'h0, 1'b0);
    check("tmr_load0", bus.DIN, 16'h0001);
`else
    cyc(16'h1000, 16'h0, 1'b0);
    cyc(16'h5000, 16'h0007, 1'b1);
    check("notmr_5000w", bus.DIN, 16'h0000);
    cyc(16'h5001, 16'h0, 1'b0);
    check("notmr_5001", bus.DIN, 16'h0000);
    cyc(16'h1000, 16'h0, 1'b0);
    cyc(16'h5000, 16'h0, 1'b0);
    check("notmr_5000", bus.DIN, 16'h0000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
